// File: rtl/n2tl_rls_arb_pkg.sv
// Shared definitions for the release arbiter: one-hot state encoding and
// parameter defaults used by the arbiter and its round-robin picker.
package n2tl_rls_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int TMO_CYC_DEF = 1024;

  typedef enum logic [4:0] {
    ARB_IDLE   = 5'b00001,
    ARB_ISSUE  = 5'b00010,
    ARB_ACK_WT = 5'b00100,
    ARB_DONE   = 5'b01000,
    ARB_ERR    = 5'b10000
  } arb_state_e;

endpackage

// File: rtl/n2tl_rls_arb_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr,
// wrapping past NREQ-1, with masked requesters skipped.
module n2tl_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic [NREQ-1:0] mask,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            vld
);

  localparam int SW = IW + 1;

  logic [NREQ-1:0] elig;
  logic [SW-1:0]   sum;
  logic [IW-1:0]   cand;

  assign elig = req & ~mask;

  // sum is one bit wider than ptr so the wrap works for non-power-of-two NREQ
  always_comb begin
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      cand = sum[IW-1:0];
      if (!vld && elig[cand]) begin
        vld         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/n2tl_rls_arb.sv
// Release arbiter: round-robin grants one requester at a time, issues a
// release event, and reports completion or timeout back to that requester.
module n2tl_rls_arb
  import n2tl_rls_pkg::*;
#(
  parameter  int NREQ    = NREQ_DEF,
  parameter  int TMO_CYC = TMO_CYC_DEF,
  localparam int IW      = $clog2(NREQ),
  localparam int TW      = $clog2(TMO_CYC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_vec,
  output logic            rls_req,
  output logic [IW-1:0]   rls_req_src,
  input  logic            rls_req_ack,
  input  logic            rls_ack_rcvd,
  output logic [NREQ-1:0] done_vec,
  output logic [NREQ-1:0] err_vec,
  output logic            busy
);

  arb_state_e      state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] src_oh;
  logic [TW-1:0]   tmo_cnt;
  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic            grant_now;
  logic            tmo_exp;

  n2tl_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req_vec),
    .ptr   (rr_ptr),
    .mask  (mask),
    .grant (pick_grant),
    .idx   (pick_idx),
    .vld   (pick_vld)
  );

  assign grant_now = (state == ARB_IDLE) && pick_vld;
  assign tmo_exp   = (tmo_cnt == TW'(TMO_CYC - 1));
  assign busy      = (state != ARB_IDLE);

  // A remote ack always beats a timeout expiring in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:   if (pick_vld) state_nxt = ARB_ISSUE;
      ARB_ISSUE: begin
        if (rls_ack_rcvd)     state_nxt = ARB_DONE;
        else if (tmo_exp)     state_nxt = ARB_ERR;
        else if (rls_req_ack) state_nxt = ARB_ACK_WT;
      end
      ARB_ACK_WT: begin
        if (rls_ack_rcvd) state_nxt = ARB_DONE;
        else if (tmo_exp) state_nxt = ARB_ERR;
      end
      ARB_DONE:   state_nxt = ARB_IDLE;
      ARB_ERR:    state_nxt = ARB_IDLE;
      default:    state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB_IDLE;
      rr_ptr      <= '0;
      mask        <= '0;
      src_oh      <= '0;
      tmo_cnt     <= '0;
      rls_req     <= 1'b0;
      rls_req_src <= '0;
      done_vec    <= '0;
      err_vec     <= '0;
    end else begin
      state    <= state_nxt;
      rls_req  <= grant_now;
      done_vec <= (state_nxt == ARB_DONE) ? src_oh : '0;
      err_vec  <= (state_nxt == ARB_ERR)  ? src_oh : '0;
      mask     <= '0;
      if (grant_now) begin
        rls_req_src <= pick_idx;
        src_oh      <= pick_grant;
        tmo_cnt     <= '0;
      end else if (state == ARB_ISSUE || state == ARB_ACK_WT) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      // Finished requester is masked for one idle cycle while it drops its request
      if (state == ARB_DONE || state == ARB_ERR) begin
        mask   <= src_oh;
        rr_ptr <= (rls_req_src == IW'(NREQ - 1)) ? '0 : rls_req_src + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_n2tl_rls_arb.sv
// Self-checking bench for n2tl_rls_arb: directed scenarios with literal
// expectations plus randomized traffic checked against a transaction model.
module tb_n2tl_rls_arb;

  localparam int NREQ = 4;
  localparam int TMO  = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req_vec;
  logic            rls_req;
  logic [1:0]      rls_req_src;
  logic            rls_req_ack;
  logic            rls_ack_rcvd;
  logic [NREQ-1:0] done_vec;
  logic [NREQ-1:0] err_vec;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  n2tl_rls_arb #(.NREQ(NREQ), .TMO_CYC(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_vec      (req_vec),
    .rls_req      (rls_req),
    .rls_req_src  (rls_req_src),
    .rls_req_ack  (rls_req_ack),
    .rls_ack_rcvd (rls_ack_rcvd),
    .done_vec     (done_vec),
    .err_vec      (err_vec),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: who is being served, how long since issue,
  // and whether this cycle is the completion pulse.
  bit              m_txn = 1'b0;
  bit              m_end = 1'b0;
  int              m_src = 0;
  int              m_age = 0;
  int              m_ptr = 0;
  int              m_mask = -1;
  int              m_pick;
  int              m_c;
  logic            exp_rls_req = 1'b0;
  logic            exp_busy = 1'b0;
  logic [NREQ-1:0] exp_done = '0;
  logic [NREQ-1:0] exp_err = '0;
  int              exp_src = 0;

  always @(posedge clk) begin
    exp_rls_req = 1'b0;
    exp_done    = '0;
    exp_err     = '0;
    if (reset) begin
      m_txn = 1'b0; m_end = 1'b0; m_src = 0; m_ptr = 0; m_mask = -1;
      exp_src = 0; exp_busy = 1'b0;
    end else if (m_end) begin
      m_end = 1'b0;
      m_ptr = (m_src + 1) % NREQ;
      m_mask = m_src;
      exp_busy = 1'b0;
    end else if (m_txn) begin
      exp_busy = 1'b1;
      if (rls_ack_rcvd) begin
        m_txn = 1'b0; m_end = 1'b1; exp_done = NREQ'(1) << m_src;
      end else if (m_age == TMO - 1) begin
        m_txn = 1'b0; m_end = 1'b1; exp_err = NREQ'(1) << m_src;
      end else begin
        m_age++;
      end
    end else begin
      m_pick = -1;
      for (int k = 0; k < NREQ; k++) begin
        m_c = (m_ptr + k) % NREQ;
        if (m_pick < 0 && req_vec[m_c] && m_c != m_mask) m_pick = m_c;
      end
      m_mask = -1;
      if (m_pick >= 0) begin
        m_txn = 1'b1; m_src = m_pick; m_age = 0;
        exp_rls_req = 1'b1; exp_busy = 1'b1; exp_src = m_pick;
      end else begin
        exp_busy = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] rq, input logic ak, input logic rc, input logic rs);
    req_vec      = rq;
    rls_req_ack  = ak;
    rls_ack_rcvd = rc;
    reset        = rs;
    @(negedge clk);
  endtask

  task automatic waitGrant(input logic [NREQ-1:0] rq, output int src);
    int n = 0;
    while (!rls_req && n < 20) begin
      applyStimulus(rq, 1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput("grant_seen", 32'(rls_req), 32'(1));
    src = int'(rls_req_src);
  endtask

  // Continuous comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("rls_req", 32'(rls_req), 32'(exp_rls_req));
      checkOutput("rls_req_src", 32'(rls_req_src), 32'(exp_src));
      checkOutput("done_vec", 32'(done_vec), 32'(exp_done));
      checkOutput("err_vec", 32'(err_vec), 32'(exp_err));
      checkOutput("busy", 32'(busy), 32'(exp_busy));
      checkOutput("done_err_excl", 32'((done_vec != 0) && (err_vec != 0)), 32'(0));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int n;
    int exp34[5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0] rq;
    logic ak, rc, rs;

    req_vec = '0; rls_req_ack = 1'b0; rls_ack_rcvd = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_rls_req", 32'(rls_req), 32'(0));
    checkOutput("rst_src", 32'(rls_req_src), 32'(0));
    checkOutput("rst_done", 32'(done_vec), 32'(0));
    checkOutput("rst_err", 32'(err_vec), 32'(0));

    // Single request, ack at +3, remote ack at +6
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("t33_rls_req", 32'(rls_req), 32'(1));
    checkOutput("t33_src", 32'(rls_req_src), 32'(2));
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b1, 1'b0);
    checkOutput("t33_done", 32'(done_vec), 32'(4'b0100));
    checkOutput("t33_busy_done", 32'(busy), 32'(1));
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("t33_busy_low", 32'(busy), 32'(0));

    // All requesting, immediate acks: strict rotation from 0
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int g = 0; g < 5; g++) begin
      waitGrant(4'b1111, s);
      checkOutput($sformatf("t34_grant%0d", g), 32'(s), 32'(exp34[g]));
      applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
    end
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    // Timeout after issue ack only
    waitGrant(4'b0001, s);
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
    n = 1;
    while (err_vec == 0 && done_vec == 0 && n < 20) begin
      applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput("t35_err_latency", 32'(n), 32'(8));
    checkOutput("t35_err_vec", 32'(err_vec), 32'(4'b0001));
    checkOutput("t35_no_done", 32'(done_vec), 32'(0));
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    // Remote ack on the expiry cycle wins
    waitGrant(4'b0010, s);
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
    repeat (6) applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b1, 1'b0);
    checkOutput("t35_race_done", 32'(done_vec), 32'(4'b0010));
    checkOutput("t35_race_no_err", 32'(err_vec), 32'(0));
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    // Remote ack before issue ack, then stray acks while idle
    waitGrant(4'b1000, s);
    checkOutput("t36_src", 32'(s), 32'(3));
    applyStimulus(4'b1000, 1'b0, 1'b1, 1'b0);
    checkOutput("t36_done", 32'(done_vec), 32'(4'b1000));
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    checkOutput("t36_stray_busy", 32'(busy), 32'(0));
    checkOutput("t36_stray_req", 32'(rls_req), 32'(0));
    checkOutput("t36_stray_done", 32'(done_vec), 32'(0));

    // Reset while waiting for the remote ack
    waitGrant(4'b0100, s);
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b1);
    checkOutput("t37_busy", 32'(busy), 32'(0));
    checkOutput("t37_rls_req", 32'(rls_req), 32'(0));
    checkOutput("t37_src", 32'(rls_req_src), 32'(0));
    checkOutput("t37_err", 32'(err_vec), 32'(0));
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("t37_late_done", 32'(done_vec), 32'(0));
    checkOutput("t37_late_busy", 32'(busy), 32'(0));

    // Randomized traffic: requests held until their completion pulse
    rq = '0;
    repeat (3000) begin
      rq = rq & ~(exp_done | exp_err);
      for (int i = 0; i < NREQ; i++)
        if (!rq[i] && $urandom_range(7) == 0) rq[i] = 1'b1;
      if ($urandom_range(63) == 0) rq = rq & NREQ'($urandom);
      ak = ($urandom_range(3) == 0);
      rc = ($urandom_range(9) == 0);
      rs = ($urandom_range(299) == 0);
      applyStimulus(rq, ak, rc, rs);
    end
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    check_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
